// File: rtl/board_step_if.sv
// Bundle between the board step controller and its environment: move handshake,
// merge-stage request/result, and the registered game state.
interface board_step_if;
  logic                  move_valid;
  logic [3:0]            move_dir;
  logic                  move_ready;
  logic [3:0]            dir_out;
  logic [3:0][3:0][11:0] merged_board;
  logic [19:0]           merged_score;
  logic [3:0][3:0][11:0] board;
  logic [19:0]           score;
  logic                  game_won;
  logic                  game_over;

  modport master (
    output move_valid, move_dir, merged_board, merged_score,
    input  move_ready, dir_out, board, score, game_won, game_over
  );

  modport slave (
    input  move_valid, move_dir, merged_board, merged_score,
    output move_ready, dir_out, board, score, game_won, game_over
  );
endinterface

// File: rtl/board_step_controller.sv
// Owns the 4x4 game board: sequences one move through the external merge stage,
// commits changed boards, spawns tiles at LFSR-chosen empty cells and tracks win/loss.
module board_step_controller #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [11:0] WIN_VALUE = 12'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  board_step_if.slave bus
);
  typedef logic [3:0][3:0][11:0] board_t;
  typedef enum logic [2:0] {S_SCAN, S_CHECK, S_IDLE, S_EVAL, S_OVER} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  board_t      board_q, board_d;
  logic [19:0] score_q, score_d;
  logic        won_q, won_d;
  logic        over_q, over_d;
  logic [3:0]  dir_q, dir_d;
  logic [1:0]  spawn_left_q, spawn_left_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] val_q, val_d;
  logic [3:0]  scanned_q, scanned_d;

  function automatic logic [11:0] spawn_val(input logic [15:0] l);
    return (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
  endfunction

  logic        board_full, has_pair, any_win, dir_onehot;
  logic [11:0] cur_cell;
  logic [20:0] score_sum;
  logic [19:0] score_sat;

  // Board properties consumed in CHECK; a stuck board is full with no equal neighbours.
  always_comb begin
    board_full = 1'b1;
    has_pair   = 1'b0;
    any_win    = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[r][c] == 12'd0)      board_full = 1'b0;
        if (board_q[r][c] >= WIN_VALUE)  any_win    = 1'b1;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[r][c] == board_q[r+1][c]) has_pair = 1'b1;
  end

  assign dir_onehot = (bus.move_dir != 4'd0) &&
                      ((bus.move_dir & (bus.move_dir - 4'd1)) == 4'd0);
  assign cur_cell   = board_q[idx_q[3:2]][idx_q[1:0]];
  assign score_sum  = {1'b0, score_q} + {1'b0, bus.merged_score};
  assign score_sat  = score_sum[20] ? 20'hFFFFF : score_sum[19:0];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    state_d      = state_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    board_d      = board_q;
    score_d      = score_q;
    won_d        = won_q;
    over_d       = over_q;
    dir_d        = dir_q;
    spawn_left_d = spawn_left_q;
    idx_d        = idx_q;
    val_d        = val_q;
    scanned_d    = scanned_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.move_valid && dir_onehot) begin
          dir_d   = bus.move_dir;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (bus.merged_board != board_q) begin
          board_d      = bus.merged_board;
          score_d      = score_sat;
          spawn_left_d = 2'd1;
          idx_d        = lfsr_q[3:0];
          val_d        = spawn_val(lfsr_q);
          scanned_d    = 4'd0;
          state_d      = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (cur_cell == 12'd0) begin
          board_d[idx_q[3:2]][idx_q[1:0]] = val_q;
          spawn_left_d = spawn_left_q - 2'd1;
          state_d      = S_CHECK;
        end else if (scanned_q == 4'd15) begin
          state_d = S_CHECK;
        end else begin
          idx_d     = idx_q + 4'd1;
          scanned_d = scanned_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (any_win) won_d = 1'b1;
        if (board_full && !has_pair) begin
          over_d  = 1'b1;
          state_d = S_OVER;
        end else if (spawn_left_q != 2'd0) begin
          idx_d     = lfsr_q[3:0];
          val_d     = spawn_val(lfsr_q);
          scanned_d = 4'd0;
          state_d   = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OVER:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q      <= S_SCAN;
      lfsr_q       <= SEED;
      board_q      <= '0;
      score_q      <= '0;
      won_q        <= 1'b0;
      over_q       <= 1'b0;
      dir_q        <= '0;
      spawn_left_q <= 2'd2;
      idx_q        <= SEED[3:0];
      val_q        <= spawn_val(SEED);
      scanned_q    <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      board_q      <= board_d;
      score_q      <= score_d;
      won_q        <= won_d;
      over_q       <= over_d;
      dir_q        <= dir_d;
      spawn_left_q <= spawn_left_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      scanned_q    <= scanned_d;
    end
  end

  assign bus.move_ready = (state_q == S_IDLE);
  assign bus.dir_out    = (state_q == S_EVAL) ? dir_q : 4'd0;
  assign bus.board      = board_q;
  assign bus.score      = score_q;
  assign bus.game_won   = won_q;
  assign bus.game_over  = over_q;
endmodule
